bsg_link_upstream_arb: RTL and testbench

//  Shares one bsg_link_ddr_upstream core-side port between NUM_REQ requesters.
//  - Arbitration is round-robin and packet-locked: a grant is held until the requester's last beat.
//  - Tracks link credits, returned by token pulses from the downstream receiver.
//  - Never issues a beat without a credit.
//  - Sits in the core clock domain, directly in front of the upstream link's core_valid_i/core_data_i.

---
 rtl/bsg_link_upstream_arb_if.sv | 38 +++
 rtl/bsg_link_upstream_arb.sv | 122 ++++++++++++
 tb/tb_bsg_link_upstream_arb.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bsg_link_upstream_arb_if.sv
// Core-side bundle between NUM_REQ requesters, the arbiter and the upstream
// link. The arbiter uses the slave modport; whoever drives requests and the
// link side (the bench, or the surrounding core) uses the master modport.
interface bsg_link_upstream_arb_if #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 64,
    parameter int CREDITS = 16
);
    localparam int GW = $clog2(NUM_REQ);
    localparam int CW = $clog2(CREDITS + 1);

    logic [NUM_REQ-1:0]        req_valid_i;
    logic [NUM_REQ-1:0]        req_last_i;
    logic [NUM_REQ*DATA_W-1:0] req_data_i;
    logic [NUM_REQ-1:0]        req_ready_o;
    logic                      link_valid_o;
    logic [DATA_W-1:0]         link_data_o;
    logic                      link_ready_i;
    logic                      token_i;
    logic [GW-1:0]             grant_id_o;
    logic [CW-1:0]             credit_cnt_o;
    logic                      err_o;
    // Debug view of the arbiter FSM: 1 while a packet lock is held.
    logic                      dbg_locked_o;
    logic [GW-1:0]             dbg_rr_ptr_o;

    modport slave (
        input  req_valid_i, req_last_i, req_data_i, link_ready_i, token_i,
        output req_ready_o, link_valid_o, link_data_o, grant_id_o,
               credit_cnt_o, err_o, dbg_locked_o, dbg_rr_ptr_o
    );

    modport master (
        output req_valid_i, req_last_i, req_data_i, link_ready_i, token_i,
        input  req_ready_o, link_valid_o, link_data_o, grant_id_o,
               credit_cnt_o, err_o, dbg_locked_o, dbg_rr_ptr_o
    );
endinterface

// File: rtl/bsg_link_upstream_arb.sv
// Round-robin, packet-locked arbiter sharing one upstream link port between
// NUM_REQ requesters, with link credit tracking fed by token pulses.
//
// Handshake: a beat moves on a requester port in a cycle where
// req_valid_i[i] & req_ready_o[i] are both high, and on the link port where
// link_valid_o & link_ready_i are both high. A valid producer keeps its beat
// stable until it is taken; the link output never changes while it is
// valid and not yet taken.
module bsg_link_upstream_arb #(
    parameter int NUM_REQ     = 4,
    parameter int DATA_W      = 64,
    parameter int CREDITS     = 16,
    parameter int TOKEN_DECIM = 4
) (
    input logic clk,
    input logic rst,
    bsg_link_upstream_arb_if.slave bus
);
    localparam int GW = $clog2(NUM_REQ);
    localparam int CW = $clog2(CREDITS + 1);
    localparam logic [CW:0] TD_W  = (CW + 1)'(TOKEN_DECIM);
    localparam logic [CW:0] CRD_W = (CW + 1)'(CREDITS);

    typedef enum logic {IDLE, LOCK} state_t;

    state_t            state;
    logic [GW-1:0]     lock_id;
    logic [GW-1:0]     rr_ptr;
    logic [CW-1:0]     credit_cnt;
    logic              err;
    logic              link_valid;
    logic [DATA_W-1:0] link_data;

    logic [GW-1:0]      winner;
    logic [GW-1:0]      grant;
    logic [GW-1:0]      rr_next;
    logic [NUM_REQ-1:0] ready;
    logic               out_free;
    logic               can_send;
    logic               accept;
    logic [CW:0]        credit_sum;
    int                 scan_idx;

    // Round-robin scan starting at rr_ptr; with nobody valid the winner is rr_ptr.
    always_comb begin
        winner   = rr_ptr;
        scan_idx = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            scan_idx = (int'(rr_ptr) + k) % NUM_REQ;
            if (bus.req_valid_i[scan_idx]) winner = GW'(scan_idx);
        end
    end

    // Grant selection, output-stage availability and the single ready bit.
    always_comb begin
        grant    = (state == LOCK) ? lock_id : winner;
        out_free = ~link_valid | bus.link_ready_i;
        can_send = out_free & (credit_cnt != '0);
        ready    = '0;
        if (can_send && !rst) ready[grant] = 1'b1;
        accept   = bus.req_valid_i[grant] & ready[grant];
        rr_next  = (grant == GW'(NUM_REQ - 1)) ? '0 : grant + 1'b1;
    end

    // Next credit count: one spent per accepted beat, TOKEN_DECIM back per token.
    always_comb begin
        credit_sum = {1'b0, credit_cnt} - {{CW{1'b0}}, accept}
                   + (bus.token_i ? TD_W : '0);
    end

    // Arbiter FSM: the lock is taken on a non-last beat and released on a last beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            lock_id <= '0;
            rr_ptr  <= '0;
        end else if (accept) begin
            if (bus.req_last_i[grant]) begin
                state  <= IDLE;
                rr_ptr <= rr_next;
            end else begin
                state   <= LOCK;
                lock_id <= grant;
            end
        end
    end

    // One-entry output register in front of the link.
    always_ff @(posedge clk) begin
        if (rst) begin
            link_valid <= 1'b0;
            link_data  <= '0;
        end else if (accept) begin
            link_valid <= 1'b1;
            link_data  <= bus.req_data_i[int'(grant)*DATA_W +: DATA_W];
        end else if (bus.link_ready_i) begin
            link_valid <= 1'b0;
        end
    end

    // Credit counter, saturating at CREDITS with a sticky overflow flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            credit_cnt <= CW'(CREDITS);
            err        <= 1'b0;
        end else if (credit_sum > CRD_W) begin
            credit_cnt <= CW'(CREDITS);
            err        <= 1'b1;
        end else begin
            credit_cnt <= credit_sum[CW-1:0];
        end
    end

    assign bus.req_ready_o  = ready;
    assign bus.grant_id_o   = rst ? '0 : grant;
    assign bus.link_valid_o = link_valid;
    assign bus.link_data_o  = link_data;
    assign bus.credit_cnt_o = credit_cnt;
    assign bus.err_o        = err;
    assign bus.dbg_locked_o = (state == LOCK);
    assign bus.dbg_rr_ptr_o = rr_ptr;
endmodule

// File: tb/tb_bsg_link_upstream_arb.sv
// Bench for bsg_link_upstream_arb: directed scenarios followed by random
// traffic, all checked against a packet/queue level reference model.
module tb_bsg_link_upstream_arb;
    localparam int N  = 4;
    localparam int DW = 64;
    localparam int CR = 16;
    localparam int TD = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    bsg_link_upstream_arb_if #(.NUM_REQ(N), .DATA_W(DW), .CREDITS(CR)) bus ();

    bsg_link_upstream_arb #(.NUM_REQ(N), .DATA_W(DW), .CREDITS(CR), .TOKEN_DECIM(TD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // clock
    always #5 clk = ~clk;

    // counters
    int n_vec  = 0;
    int n_fail = 0;

    // reference model state
    logic [DW-1:0] exp_q[$];   // beats sitting in the link output stage
    int m_credits;
    bit m_err;
    bit m_locked;
    int m_owner;
    int m_rr;
    int m_acc_id;              // requester the model says was accepted, -1 none
    int obs_acc;               // requester the DUT accepted, -1 none

    int src_left[N];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_credits = CR;
        m_err     = 1'b0;
        m_locked  = 1'b0;
        m_owner   = 0;
        m_rr      = 0;
    endtask

    task automatic drive_idle();
        bus.req_valid_i  = '0;
        bus.req_last_i   = '0;
        bus.req_data_i   = '0;
        bus.link_ready_i = 1'b1;
        bus.token_i      = 1'b0;
    endtask

    task automatic set_req(input int i, input bit v, input bit l, input logic [DW-1:0] d);
        bus.req_valid_i[i]           = v;
        bus.req_last_i[i]            = l;
        bus.req_data_i[i*DW +: DW]   = d;
    endtask

    // One clock cycle: inputs are already set (just after a falling edge).
    // Check DUT against the model, advance the model, cross the rising edge.
    task automatic step();
        int g;
        bit any_v;
        bit send_ok;
        logic [N-1:0] exp_acc;
        logic [N-1:0] got_acc;
        #1;
        chk("link_valid", bus.link_valid_o, exp_q.size() != 0);
        if (exp_q.size() != 0) chk("link_data", bus.link_data_o, exp_q[0]);
        chk("credit_cnt", bus.credit_cnt_o, m_credits);
        chk("err", bus.err_o, m_err);

        // who should hold the grant
        any_v = 1'b0;
        g = m_rr;
        if (m_locked) begin
            g = m_owner;
        end else begin
            for (int k = 0; k < N; k++) begin
                if (!any_v && bus.req_valid_i[(m_rr + k) % N]) begin
                    g = (m_rr + k) % N;
                    any_v = 1'b1;
                end
            end
        end
        send_ok = (exp_q.size() == 0 || bus.link_ready_i) && m_credits > 0 && !rst;
        exp_acc = '0;
        if (send_ok && bus.req_valid_i[g]) exp_acc[g] = 1'b1;
        got_acc = bus.req_ready_o & bus.req_valid_i;
        chk("accept", got_acc, exp_acc);
        chk("ready_onehot", $countones(bus.req_ready_o) <= 1, 1'b1);
        if (rst) begin
            chk("rst_ready", bus.req_ready_o, '0);
            chk("rst_grant", bus.grant_id_o, 0);
        end else if (m_locked || any_v) begin
            chk("grant", bus.grant_id_o, g);
        end

        obs_acc = -1;
        for (int i = 0; i < N; i++) if (got_acc[i]) obs_acc = i;

        // advance the model over the rising edge
        m_acc_id = -1;
        if (rst) begin
            model_reset();
        end else begin
            if (bus.link_ready_i && exp_q.size() != 0) void'(exp_q.pop_front());
            if (exp_acc != '0) begin
                m_acc_id = g;
                exp_q.push_back(bus.req_data_i[g*DW +: DW]);
                m_credits = m_credits - 1;
                if (bus.req_last_i[g]) begin
                    m_locked = 1'b0;
                    m_rr = (g + 1) % N;
                end else begin
                    m_locked = 1'b1;
                    m_owner = g;
                end
            end
            if (bus.token_i) m_credits = m_credits + TD;
            if (m_credits > CR) begin
                m_credits = CR;
                m_err = 1'b1;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        int cnt;
        int order[4];
        int seq3[5];
        logic [DW-1:0] held;

        drive_idle();
        model_reset();
        for (int i = 0; i < N; i++) src_left[i] = 1;
        @(negedge clk);

        // T1: reset values, then a single-beat packet from req0
        rst = 1'b1;
        step();
        step();
        #1;
        chk("t1_rst_valid", bus.link_valid_o, 0);
        chk("t1_rst_data", bus.link_data_o, 0);
        chk("t1_rst_ready", bus.req_ready_o, 0);
        chk("t1_rst_grant", bus.grant_id_o, 0);
        chk("t1_rst_credit", bus.credit_cnt_o, 16);
        chk("t1_rst_err", bus.err_o, 0);
        rst = 1'b0;
        set_req(0, 1, 1, 64'hA5);
        step();
        chk("t1_accept", obs_acc, 0);
        set_req(0, 0, 0, 64'h0);
        #1;
        chk("t1_valid", bus.link_valid_o, 1);
        chk("t1_data", bus.link_data_o, 64'hA5);
        chk("t1_credit", bus.credit_cnt_o, 15);
        step();

        // T2: req1 and req3 compete with single-beat packets
        order = '{1, 3, 1, 3};
        for (int c = 0; c < 4; c++) begin
            set_req(1, 1, 1, 64'h100 + 64'(c));
            set_req(3, 1, 1, 64'h300 + 64'(c));
            step();
            chk("t2_order", obs_acc, order[c]);
        end
        drive_idle();
        step();

        // T3: 3-beat packet from req2 with a bubble; req0 must wait
        seq3 = '{2, 2, -1, 2, 0};
        for (int c = 0; c < 5; c++) begin
            drive_idle();
            if (c != 2 && c != 4) set_req(2, 1, (c == 3), 64'h200 + 64'(c));
            if (c >= 1) set_req(0, 1, 1, 64'hC0 + 64'(c));
            if (c == 2) begin
                #1;
                chk("t3_bubble_grant", bus.grant_id_o, 2);
            end
            step();
            chk("t3_seq", obs_acc, seq3[c]);
        end
        drive_idle();
        step();

        // T4: credit exhaustion and one token
        rst = 1'b1;
        step();
        rst = 1'b0;
        cnt = 0;
        for (int c = 0; c < 20; c++) begin
            set_req(0, 1, 1, {$urandom, $urandom});
            step();
            if (obs_acc >= 0) cnt++;
        end
        chk("t4_accepted16", cnt, 16);
        #1;
        chk("t4_ready_zero", bus.req_ready_o, 0);
        bus.token_i = 1'b1;
        step();
        chk("t4_no_acc_on_token", obs_acc, -1);
        bus.token_i = 1'b0;
        cnt = 0;
        for (int c = 0; c < 8; c++) begin
            set_req(0, 1, 1, {$urandom, $urandom});
            step();
            if (obs_acc >= 0) cnt++;
        end
        chk("t4_accepted4", cnt, 4);
        chk("t4_credit0", bus.credit_cnt_o, 0);

        // T5: link stall with a beat pending
        drive_idle();
        bus.token_i = 1'b1;
        step();
        bus.token_i = 1'b0;
        bus.link_ready_i = 1'b0;
        set_req(1, 1, 1, 64'hDEAD_BEEF_0000_0001);
        step();
        chk("t5_first_acc", obs_acc, 1);
        held = 64'hDEAD_BEEF_0000_0001;
        cnt = 0;
        for (int c = 0; c < 5; c++) begin
            set_req(1, 1, 1, {$urandom, $urandom});
            step();
            if (obs_acc >= 0) cnt++;
            chk("t5_valid", bus.link_valid_o, 1);
            chk("t5_data", bus.link_data_o, held);
        end
        chk("t5_no_acc", cnt, 0);
        chk("t5_credit", bus.credit_cnt_o, 3);

        // T6: token overflow, then reset mid-packet
        drive_idle();
        for (int c = 0; c < 5; c++) begin
            bus.token_i = 1'b1;
            step();
        end
        bus.token_i = 1'b0;
        chk("t6_err", bus.err_o, 1);
        chk("t6_credit", bus.credit_cnt_o, 16);
        set_req(1, 1, 0, 64'h1111);
        step();
        chk("t6_lock_acc", obs_acc, 1);
        drive_idle();
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        chk("t6_rst_err", bus.err_o, 0);
        chk("t6_rst_credit", bus.credit_cnt_o, 16);
        chk("t6_rst_valid", bus.link_valid_o, 0);
        chk("t6_rst_data", bus.link_data_o, 0);
        set_req(0, 1, 1, 64'h2222);
        set_req(1, 1, 1, 64'h3333);
        step();
        chk("t6_idle_grant", obs_acc, 0);
        drive_idle();
        step();

        // Random traffic
        for (int i = 0; i < N; i++) src_left[i] = $urandom_range(1, 4);
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++)
                set_req(i, $urandom_range(0, 9) < 6, src_left[i] == 1, {$urandom, $urandom});
            bus.link_ready_i = $urandom_range(0, 9) < 8;
            bus.token_i      = $urandom_range(0, 19) < 5;
            rst              = $urandom_range(0, 499) == 0;
            step();
            if (m_acc_id >= 0) begin
                src_left[m_acc_id]--;
                if (src_left[m_acc_id] == 0) src_left[m_acc_id] = $urandom_range(1, 4);
            end
        end
        rst = 1'b0;
        drive_idle();
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
